// File: rtl/sha256_digest_reader.sv
// Digest read-out buffer: snapshots H0..H7 on capture and streams them
// over a valid/ready handshake, H0 first, so the core can move on at once.
module sha256_digest_reader #(
   parameter int DW     = 32,
   parameter int NWORDS = 8,
   parameter int IDXW   = 3
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 capture,
   input  logic [DW*NWORDS-1:0] digest_i,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        out_data,
   output logic [IDXW-1:0]      out_idx,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done,
   output logic                 overrun,
   input  logic                 clr_overrun
);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

   state_e               state_q, state_d;
   logic [DW*NWORDS-1:0] snap_q, snap_d;
   logic [IDXW-1:0]      idx_q, idx_d;
   logic [DW-1:0]        data_q, data_d;
   logic                 last_q, last_d;
   logic                 ovr_q, ovr_d;

   logic [DW-1:0]        words [NWORDS];
   logic [IDXW-1:0]      idx_inc;

   // Word 0 (H0) sits in the most significant slice of the snapshot.
   always_comb begin
      for (int k = 0; k < NWORDS; k++) begin
         words[k] = snap_q[(NWORDS-1-k)*DW +: DW];
      end
   end

   assign idx_inc = idx_q + IDXW'(1);

   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      idx_d   = idx_q;
      data_d  = data_q;
      last_d  = last_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (capture) begin
               snap_d  = digest_i;
               idx_d   = '0;
               data_d  = digest_i[DW*NWORDS-1 -: DW];
               last_d  = (NWORDS == 1);
               state_d = SEND;
            end
         end
         SEND: begin
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
                  idx_d   = '0;
                  data_d  = '0;
                  last_d  = 1'b0;
               end else begin
                  idx_d  = idx_inc;
                  data_d = words[idx_inc];
                  last_d = (idx_inc == LAST_IDX);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A capture while busy outranks a coincident clear.
   always_comb begin
      ovr_d = ovr_q;
      if (clr_overrun) ovr_d = 1'b0;
      if (capture && state_q == SEND) ovr_d = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         snap_q  <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         last_q  <= last_d;
         ovr_q   <= ovr_d;
      end
   end

   assign out_valid = (state_q == SEND);
   assign busy      = (state_q == SEND);
   assign done      = (state_q == DONE);
   assign out_data  = data_q;
   assign out_idx   = idx_q;
   assign out_last  = last_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Bench for sha256_digest_reader: directed scenarios plus random traffic,
// scored against a queue model of the expected word stream.
module tb_sha256_digest_reader;

   localparam int DW = 32;
   localparam int NW = 8;
   localparam int IW = 3;

   logic            CLK = 1'b0;
   logic            RST = 1'b0;
   logic            capture = 1'b0;
   logic [DW*NW-1:0] digest_i = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [DW-1:0]   out_data;
   logic [IW-1:0]   out_idx;
   logic            out_last;
   logic            busy;
   logic            done;
   logic            overrun;
   logic            clr_overrun = 1'b0;

   sha256_digest_reader #(.DW(DW), .NWORDS(NW), .IDXW(IW)) dut (
      .CLK(CLK), .RST(RST), .capture(capture), .digest_i(digest_i),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done),
      .overrun(overrun), .clr_overrun(clr_overrun)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of words still owed to the consumer.
   logic [DW-1:0] exp_q [$];
   bit            m_ovr  = 1'b0;
   bit            m_done = 1'b0;
   int            xfers  = 0;

   localparam logic [DW*NW-1:0] ABC = {
      32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
   localparam logic [DW*NW-1:0] SEQ = {
      32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: advance the model from pre-edge inputs, then compare.
   task automatic tick();
      int rem;
      rem = exp_q.size();
      if (out_valid && out_ready) xfers++;
      if (!RST) begin
         exp_q.delete();
         m_ovr  = 1'b0;
         m_done = 1'b0;
      end else begin
         m_done = (rem > 0) && out_ready && (rem == 1);
         if (rem > 0 && out_ready) void'(exp_q.pop_front());
         if (clr_overrun) m_ovr = 1'b0;
         if (capture && rem > 0) m_ovr = 1'b1;
         if (capture && rem == 0)
            for (int k = 0; k < NW; k++) exp_q.push_back(digest_i[(NW-1-k)*DW +: DW]);
      end
      @(posedge CLK);
      #1;
      check("valid", 32'(out_valid), 32'(exp_q.size() > 0));
      check("busy", 32'(busy), 32'(exp_q.size() > 0));
      check("done", 32'(done), 32'(m_done));
      check("overrun", 32'(overrun), 32'(m_ovr));
      if (exp_q.size() > 0) begin
         check("data", out_data, exp_q[0]);
         check("idx", 32'(out_idx), 32'(NW - exp_q.size()));
         check("last", 32'(out_last), 32'(exp_q.size() == 1));
      end else begin
         check("last_idle", 32'(out_last), 32'd0);
      end
   endtask

   task automatic pulse_capture(input logic [DW*NW-1:0] d);
      digest_i = d;
      capture  = 1'b1;
      tick();
      capture  = 1'b0;
   endtask

   initial begin
      // Reset state
      RST = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      check("rst_data", out_data, 32'd0);
      check("rst_idx", 32'(out_idx), 32'd0);

      // Ready high in IDLE, no capture
      RST = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("idle_data", out_data, 32'd0);
      check("idle_idx", 32'(out_idx), 32'd0);

      // abc digest, ready held high
      xfers = 0;
      pulse_capture(ABC);
      check("abc_h0", out_data, 32'hba7816bf);
      for (int i = 0; i < 12; i++) tick();
      check("abc_xfers", 32'(xfers), 32'd8);

      // abc digest, ready 1,0,0,1,...
      xfers = 0;
      pulse_capture(ABC);
      for (int i = 0; i < 40; i++) begin
         out_ready = (i % 4 == 0) || (i % 4 == 3);
         tick();
      end
      check("toggle_xfers", 32'(xfers), 32'd8);

      // Overrun: second capture during word 3
      out_ready = 1'b1;
      pulse_capture(ABC);
      for (int i = 0; i < 10 && out_idx != 3'd3; i++) tick();
      check("at_word3", 32'(out_idx), 32'd3);
      pulse_capture({NW{32'hffffffff}});
      check("ovr_set", 32'(overrun), 32'd1);
      for (int i = 0; i < 8; i++) tick();
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      check("ovr_clr", 32'(overrun), 32'd0);

      // Capture in the DONE cycle
      pulse_capture(ABC);
      for (int i = 0; i < 12 && !done; i++) tick();
      check("done_seen", 32'(done), 32'd1);
      pulse_capture(SEQ);
      check("seq_h0", out_data, 32'd1);
      check("seq_noovr", 32'(overrun), 32'd0);
      for (int i = 0; i < 10; i++) tick();

      // Reset during word 5 with ready low
      pulse_capture(ABC);
      for (int i = 0; i < 10 && out_idx != 3'd5; i++) tick();
      check("at_word5", 32'(out_idx), 32'd5);
      out_ready = 1'b0;
      tick();
      RST = 1'b0;
      tick();
      check("mid_rst_data", out_data, 32'd0);
      check("mid_rst_idx", 32'(out_idx), 32'd0);
      RST = 1'b1;
      out_ready = 1'b1;
      pulse_capture(ABC);
      check("restart_h0", out_data, 32'hba7816bf);
      for (int i = 0; i < 10; i++) tick();

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         for (int k = 0; k < NW; k++) digest_i[k*DW +: DW] = $urandom;
         capture     = ($urandom_range(0, 9) == 0);
         out_ready   = ($urandom_range(0, 2) != 0);
         clr_overrun = ($urandom_range(0, 19) == 0);
         RST         = ($urandom_range(0, 199) != 0);
         tick();
      end
      capture = 1'b0;
      clr_overrun = 1'b0;
      RST = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      check("drained", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
